dcache_wb: RTL and testbench
============================

# dcache_wb

Direct-mapped, write-back, write-allocate data cache between the core's WB-stage memory access (address, store data, byte write enables, read request) and a word-serial main-memory port. It replaces the core's direct data-RAM port and drives the existing DCacheMiss stall input of the hazard unit. Hits complete without stalling. A miss holds DCacheMiss high until the line is written back (if dirty), refilled and installed.

## Interface
Parameters:
- LINE_ADDR_LEN, 3: log2 of words per line (W = 8).
- SET_ADDR_LEN, 6: log2 of number of sets (S = 64).
- TAG_ADDR_LEN, 32-2-LINE_ADDR_LEN-SET_ADDR_LEN: tag width (derived, not overridable).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-low.
- rd_req  in  1  load request this cycle.
- wr_req  in  4  byte write enables; non-zero means store request.
- addr  in  32  byte address; bits [1:0] ignored.
- wr_data  in  32  store data, byte-lane aligned.
- rd_data  out  32  load data, registered.
- miss  out  1  request not yet serviceable; core stalls while high.
- mem_req  out  1  memory word transfer request.
- mem_we  out  1  1 = write-back word, 0 = refill word.
- mem_addr  out  32  word-aligned memory address.
- mem_wdata  out  32  write-back data.
- mem_rdata  in  32  refill data, valid when mem_ack = 1.
- mem_ack  in  1  completes the current transfer this cycle.
- hit_cnt  out  32  hit counter (see Configuration).
- miss_cnt  out  32  miss counter (see Configuration).

## Operation
- Address split: tag = addr[31:32-TAG_ADDR_LEN], set = next SET_ADDR_LEN bits, word = addr[LINE_ADDR_LEN+1:2].
- Per set: valid, dirty, tag, W data words.
- Hit = request AND valid[set] AND tag match AND state IDLE.
- Load hit: rd_data <= selected word at the clock edge.
- Store hit: the enabled bytes are written at the edge and dirty is set.
- Store with wr_req = 0 is not a request. rd_req together with a non-zero wr_req is treated as a store.
- FSM states: IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK.
  - IDLE: on a request miss, latch tag, set and word. Go to SWAP_OUT if the victim is valid and dirty, otherwise go to SWAP_IN.
  - SWAP_OUT: word counter runs 0..W-1. mem_we = 1. mem_addr = {victim tag, set, cnt, 2'b00}. After the ack on word W-1, clear the counter and go to SWAP_IN.
  - SWAP_IN: mem_we = 0. mem_addr = {latched tag, set, cnt, 2'b00}. Each acked word is written into a line buffer. After the ack on word W-1, go to SWAP_IN_OK.
  - SWAP_IN_OK: install the line buffer, the latched tag, valid = 1 and dirty = 0. Go to IDLE.
- The replayed request then hits in IDLE and performs the load or store normally.
- miss = (request AND NOT hit) OR (state != IDLE). It is combinational.
- Once a miss has been latched, the refill completes even if the request drops. The core must hold the request while miss is high.

## Timing
- Reset values: all valid and dirty bits = 0, state IDLE, counter 0, rd_data = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, hit_cnt = 0, miss_cnt = 0.
- Reset asserted mid-refill: abort immediately and drop mem_req asynchronously. Partial line is discarded and the line stays invalid.
- Hit latency: rd_data is valid in the cycle after the hit cycle, matching the WB-stage data-RAM timing. miss stays low on a hit.
- mem_req is high in SWAP_OUT and SWAP_IN. mem_addr and mem_wdata are stable until mem_ack. The address advances in the cycle after the ack, and mem_req may remain high across words.
- With mem_ack returned in the same cycle as the request:
  - clean miss: miss high for W+2 cycles (detect, W transfers, install);
  - dirty miss: miss high for 2W+2 cycles.
- Word counter wraps from W-1 to 0 only at a state change.
- A store hit and a load hit to the same address in consecutive cycles: the load returns the stored bytes.

## Configuration
- DCACHE_PERF_CNT_EN defined:
  - hit_cnt increments on each IDLE-state hit;
  - miss_cnt increments once per IDLE-state miss detection, not per stalled cycle;
  - both counters are 32-bit and wrap.
- DCACHE_PERF_CNT_EN undefined: counters are not built, and both ports are tied to 0.

## Structure
- Package dcache_pkg holds:
  - the FSM state enum (IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK);
  - derived widths W, S and TAG_ADDR_LEN as localparam functions of the parameters.
- Sub-module dcache_array holds the tag, valid, dirty and data arrays. It has one read port and one write port with per-byte enables and a whole-line install port. The FSM and the memory interface stay in dcache_wb.

## Test plan
All scenarios use default parameters and a memory that acks in the same cycle, unless stated otherwise.
- Cold load at 0x0000_0100 with memory word k = 0xA000_0000+k: miss high for 10 cycles and mem_addr steps 0x100..0x11C; rd_data = 0xA000_0000 one cycle after miss falls.
- Store hit 0x0000_0104 with wr_req = 4'b0011 and wr_data = 0x1234_5678, then load of 0x104: returns 0xA000_5678 with no miss.
- Load 0x0000_0904 (same set, different tag) after the dirty store: 8 writes (mem_we = 1) to 0x100..0x11C carrying the stored line, then 8 reads; miss high for 18 cycles.
- Memory with a 3-cycle ack delay on a clean miss: mem_addr stays stable until each ack; miss high for 34 cycles.
- rst pulsed low during SWAP_IN word 4: mem_req = 0 immediately; a following load of the same address misses again.
- With DCACHE_PERF_CNT_EN: 3 misses and 5 hits give miss_cnt = 3 and hit_cnt = 5. Without the macro, both read 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: FSM state type and geometry helpers shared by dcache_wb and dcache_array.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SWAP_OUT   = 2'd1,
        SWAP_IN    = 2'd2,
        SWAP_IN_OK = 2'd3
    } dc_state_e;

    function automatic int words_per_line(input int line_addr_len);
        return 1 << line_addr_len;
    endfunction

    function automatic int num_sets(input int set_addr_len);
        return 1 << set_addr_len;
    endfunction

    function automatic int tag_width(input int line_addr_len, input int set_addr_len);
        return 32 - 2 - line_addr_len - set_addr_len;
    endfunction

    localparam int DC_LINE_ADDR_LEN = 3;
    localparam int DC_SET_ADDR_LEN  = 6;
    localparam int DC_W             = words_per_line(DC_LINE_ADDR_LEN);
    localparam int DC_S             = num_sets(DC_SET_ADDR_LEN);
    localparam int DC_TAG_LEN       = tag_width(DC_LINE_ADDR_LEN, DC_SET_ADDR_LEN);

endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/dirty/tag/data storage. Asynchronous read of one set,
// byte-enabled single-word write (marks dirty), whole-line install (clean, valid).
module dcache_array
    import dcache_pkg::*;
#(
    parameter int  LINE_ADDR_LEN = DC_LINE_ADDR_LEN,
    parameter int  SET_ADDR_LEN  = DC_SET_ADDR_LEN,
    localparam int W             = words_per_line(LINE_ADDR_LEN),
    localparam int TAG_ADDR_LEN  = tag_width(LINE_ADDR_LEN, SET_ADDR_LEN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SET_ADDR_LEN-1:0]  rd_set,
    output logic                     rd_valid,
    output logic                     rd_dirty,
    output logic [TAG_ADDR_LEN-1:0]  rd_tag,
    output logic [W-1:0][31:0]       rd_line,
    input  logic                     wr_en,
    input  logic [SET_ADDR_LEN-1:0]  wr_set,
    input  logic [LINE_ADDR_LEN-1:0] wr_word,
    input  logic [3:0]               wr_be,
    input  logic [31:0]              wr_data,
    input  logic                     inst_en,
    input  logic [SET_ADDR_LEN-1:0]  inst_set,
    input  logic [TAG_ADDR_LEN-1:0]  inst_tag,
    input  logic [W-1:0][31:0]       inst_line
);
    localparam int S = num_sets(SET_ADDR_LEN);

    logic [S-1:0]            valid_q, valid_d;
    logic [S-1:0]            dirty_q, dirty_d;
    logic [TAG_ADDR_LEN-1:0] tag_q  [S];
    logic [TAG_ADDR_LEN-1:0] tag_d  [S];
    logic [W-1:0][31:0]      data_q [S];
    logic [W-1:0][31:0]      data_d [S];

    assign rd_valid = valid_q[rd_set];
    assign rd_dirty = dirty_q[rd_set];
    assign rd_tag   = tag_q[rd_set];
    assign rd_line  = data_q[rd_set];

    // Next array contents: store-hit byte write or refill install.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            dirty_d[wr_set] = 1'b1;
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    data_d[wr_set][wr_word][8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
        if (inst_en) begin
            valid_d[inst_set] = 1'b1;
            dirty_d[inst_set] = 1'b0;
            tag_d[inst_set]   = inst_tag;
            data_d[inst_set]  = inst_line;
        end
    end

    // Valid and dirty bits reset to an empty cache; an aborted refill never installs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data contents are meaningless until the line is valid, so no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped, write-back, write-allocate data cache with a
// word-serial memory port. Optional hit/miss counters under DCACHE_PERF_CNT_EN.
module dcache_wb
    import dcache_pkg::*;
#(
    parameter int  LINE_ADDR_LEN = 3,
    parameter int  SET_ADDR_LEN  = 6,
    localparam int TAG_ADDR_LEN  = tag_width(LINE_ADDR_LEN, SET_ADDR_LEN)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic [3:0]  wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int W = words_per_line(LINE_ADDR_LEN);
    localparam logic [LINE_ADDR_LEN-1:0] LAST_WORD = {LINE_ADDR_LEN{1'b1}};
    localparam logic [LINE_ADDR_LEN-1:0] WORD0     = '0;

    logic [TAG_ADDR_LEN-1:0]  req_tag;
    logic [SET_ADDR_LEN-1:0]  req_set;
    logic [LINE_ADDR_LEN-1:0] req_word;
    logic                     req, is_store, hit;
    logic                     unused_addr;

    dc_state_e                state_q, state_d;
    logic [LINE_ADDR_LEN-1:0] cnt_q, cnt_d, cnt_inc;
    logic [TAG_ADDR_LEN-1:0]  tag_q, tag_d;
    logic [SET_ADDR_LEN-1:0]  set_q, set_d;
    logic [W-1:0][31:0]       buf_q, buf_d;
    logic [31:0]              rd_data_q, rd_data_d;
    logic                     mem_req_q, mem_req_d;
    logic                     mem_we_q, mem_we_d;
    logic [31:0]              mem_addr_q, mem_addr_d;
    logic [31:0]              mem_wdata_q, mem_wdata_d;

    logic [SET_ADDR_LEN-1:0]  arr_rd_set;
    logic                     arr_valid, arr_dirty, arr_wr_en, arr_inst_en;
    logic [TAG_ADDR_LEN-1:0]  arr_tag;
    logic [W-1:0][31:0]       arr_line;

    assign req_tag     = addr[31 -: TAG_ADDR_LEN];
    assign req_set     = addr[LINE_ADDR_LEN+2 +: SET_ADDR_LEN];
    assign req_word    = addr[2 +: LINE_ADDR_LEN];
    assign unused_addr = ^addr[1:0];

    // A non-zero byte enable wins over rd_req, so a combined request is a store.
    assign is_store = |wr_req;
    assign req      = rd_req | is_store;
    assign hit      = req && arr_valid && (arr_tag == req_tag) && (state_q == IDLE);
    assign miss     = (req && !hit) || (state_q != IDLE);
    assign cnt_inc  = cnt_q + 1'b1;

    // Outside IDLE the array is read at the latched set to stream the victim line.
    assign arr_rd_set = (state_q == IDLE) ? req_set : set_q;

    dcache_array #(
        .LINE_ADDR_LEN(LINE_ADDR_LEN),
        .SET_ADDR_LEN (SET_ADDR_LEN)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_set   (arr_rd_set),
        .rd_valid (arr_valid),
        .rd_dirty (arr_dirty),
        .rd_tag   (arr_tag),
        .rd_line  (arr_line),
        .wr_en    (arr_wr_en),
        .wr_set   (req_set),
        .wr_word  (req_word),
        .wr_be    (wr_req),
        .wr_data  (wr_data),
        .inst_en  (arr_inst_en),
        .inst_set (set_q),
        .inst_tag (tag_q),
        .inst_line(buf_q)
    );

    // Next-state and registered-output logic for the miss handling FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tag_d       = tag_q;
        set_d       = set_q;
        buf_d       = buf_q;
        rd_data_d   = rd_data_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        arr_wr_en   = 1'b0;
        arr_inst_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    if (is_store) arr_wr_en = 1'b1;
                    else          rd_data_d = arr_line[req_word];
                end else if (req) begin
                    tag_d     = req_tag;
                    set_d     = req_set;
                    cnt_d     = WORD0;
                    mem_req_d = 1'b1;
                    if (arr_valid && arr_dirty) begin
                        state_d     = SWAP_OUT;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {arr_tag, req_set, WORD0, 2'b00};
                        mem_wdata_d = arr_line[0];
                    end else begin
                        state_d    = SWAP_IN;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {req_tag, req_set, WORD0, 2'b00};
                    end
                end
            end
            SWAP_OUT: begin
                if (mem_ack) begin
                    if (cnt_q == LAST_WORD) begin
                        cnt_d      = WORD0;
                        state_d    = SWAP_IN;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {tag_q, set_q, WORD0, 2'b00};
                    end else begin
                        cnt_d       = cnt_inc;
                        mem_addr_d  = {arr_tag, set_q, cnt_inc, 2'b00};
                        mem_wdata_d = arr_line[cnt_inc];
                    end
                end
            end
            SWAP_IN: begin
                if (mem_ack) begin
                    buf_d[cnt_q] = mem_rdata;
                    if (cnt_q == LAST_WORD) begin
                        cnt_d     = WORD0;
                        state_d   = SWAP_IN_OK;
                        mem_req_d = 1'b0;
                    end else begin
                        cnt_d      = cnt_inc;
                        mem_addr_d = {tag_q, set_q, cnt_inc, 2'b00};
                    end
                end
            end
            SWAP_IN_OK: begin
                arr_inst_en = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and output registers; reset aborts any transfer and drops mem_req at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tag_q       <= '0;
            set_q       <= '0;
            buf_q       <= '0;
            rd_data_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            set_q       <= set_d;
            buf_q       <= buf_d;
            rd_data_q   <= rd_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Hits count per IDLE hit; misses count once at detection, not per stall cycle.
    always_comb begin
        hit_cnt_d  = hit_cnt_q + {31'd0, hit};
        miss_cnt_d = miss_cnt_q + {31'd0, (req && !hit && (state_q == IDLE))};
    end

    // Free-running wrapping performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_wb.sv
// tb_dcache_wb: directed bench for dcache_wb with a word-serial memory model
// whose ack delay is programmable.
module tb_dcache_wb;
    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [3:0]  wr_req;
    logic [31:0] addr, wr_data, rd_data;
    logic        miss, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    dcache_wb dut (
        .clk      (clk),
        .rst      (rst),
        .rd_req   (rd_req),
        .wr_req   (wr_req),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .miss     (miss),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    // Memory model: word k of the lines used below holds <prefix>000_000k.
    logic [31:0] mem [4096];
    int          ack_delay = 0;
    int          wait_cnt  = 0;

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] w;
        w = 32'(i & 7);
        case (i >> 3)
            32'h08:  return 32'hA000_0000 | w;
            32'h48:  return 32'hB000_0000 | w;
            32'h10:  return 32'hC000_0000 | w;
            32'h18:  return 32'hD000_0000 | w;
            32'h20:  return 32'hE000_0000 | w;
            32'h28:  return 32'hF000_0000 | w;
            default: return 32'h0;
        endcase
    endfunction

    assign mem_ack   = mem_req && (wait_cnt == ack_delay);
    assign mem_rdata = mem[mem_addr[13:2]];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 0;
            for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
        end else begin
            if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
            else                     wait_cnt <= 0;
            if (mem_req && mem_ack && mem_we) mem[mem_addr[13:2]] <= mem_wdata;
        end
    end

    // Transfer log and address/data stability monitor.
    logic [31:0] log_addr[$];
    logic [31:0] log_wdata[$];
    logic        log_we[$];
    int          unstable  = 0;
    logic        pend_prev = 1'b0;
    logic [31:0] addr_prev = '0;
    logic [31:0] wdata_prev = '0;

    always @(negedge clk) begin
        if (pend_prev && rst && (mem_addr != addr_prev || mem_wdata != wdata_prev))
            unstable = unstable + 1;
        pend_prev  = mem_req && !mem_ack;
        addr_prev  = mem_addr;
        wdata_prev = mem_wdata;
        if (mem_req && mem_ack) begin
            log_addr.push_back(mem_addr);
            log_wdata.push_back(mem_wdata);
            log_we.push_back(mem_we);
        end
    end

    function automatic logic [31:0] la(input int i);
        return (i < log_addr.size()) ? log_addr[i] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] ld(input int i);
        return (i < log_wdata.size()) ? log_wdata[i] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] lw(input int i);
        return (i < log_we.size()) ? {31'd0, log_we[i]} : 32'hDEAD_BEEF;
    endfunction

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Holds one request until it is serviced; returns stall cycles and the load data.
    task automatic access(input logic rd, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] wd, output int mcyc, output logic [31:0] rdat);
        rd_req  = rd;
        wr_req  = be;
        addr    = a;
        wr_data = wd;
        mcyc    = 0;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (!miss) break;
            mcyc++;
            @(negedge clk);
        end
        @(negedge clk);
        rd_req = 1'b0;
        wr_req = 4'b0;
        rdat   = rd_data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          mc, base;
        logic [31:0] rd;
        logic        found;
        logic [31:0] exp_hits, exp_misses;

        rst = 1'b0; rd_req = 1'b0; wr_req = 4'b0; addr = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_miss", {31'd0, miss}, 32'h0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_hit_cnt", hit_cnt, 32'h0);
        chk("rst_miss_cnt", miss_cnt, 32'h0);
        @(negedge clk);

        // Cold clean miss.
        base = log_addr.size();
        access(1'b1, 4'b0000, 32'h0000_0100, 32'h0, mc, rd);
        chk("cold_miss_cycles", mc, 10);
        chk("cold_rd_data", rd, 32'hA000_0000);
        chk("cold_xfers", log_addr.size() - base, 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("cold_addr%0d", k), la(base + k), 32'h100 + 4 * k);
            chk($sformatf("cold_we%0d", k), lw(base + k), 32'h0);
        end

        // Store hit then immediate load of the same word.
        access(1'b0, 4'b0011, 32'h0000_0104, 32'h1234_5678, mc, rd);
        chk("st_hit_miss_cycles", mc, 0);
        access(1'b1, 4'b0000, 32'h0000_0104, 32'h0, mc, rd);
        chk("ld_after_st_miss_cycles", mc, 0);
        chk("ld_after_st_data", rd, 32'hA000_5678);

        // Dirty victim: write-back then refill.
        base = log_addr.size();
        access(1'b1, 4'b0000, 32'h0000_0904, 32'h0, mc, rd);
        chk("dirty_miss_cycles", mc, 18);
        chk("dirty_rd_data", rd, 32'hB000_0001);
        chk("dirty_xfers", log_addr.size() - base, 16);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("wb_addr%0d", k), la(base + k), 32'h100 + 4 * k);
            chk($sformatf("wb_we%0d", k), lw(base + k), 32'h1);
            chk($sformatf("wb_data%0d", k), ld(base + k),
                (k == 1) ? 32'hA000_5678 : (32'hA000_0000 + k));
            chk($sformatf("rf_addr%0d", k), la(base + 8 + k), 32'h900 + 4 * k);
            chk($sformatf("rf_we%0d", k), lw(base + 8 + k), 32'h0);
        end
        chk("mem_wb_word1", mem[32'h41], 32'hA000_5678);

        // Slow memory: 3 wait cycles before every ack.
        ack_delay = 3;
        base = log_addr.size();
        access(1'b1, 4'b0000, 32'h0000_0200, 32'h0, mc, rd);
        ack_delay = 0;
        chk("slow_miss_cycles", mc, 34);
        chk("slow_rd_data", rd, 32'hC000_0000);
        chk("slow_xfers", log_addr.size() - base, 8);
        for (int k = 0; k < 8; k++)
            chk($sformatf("slow_addr%0d", k), la(base + k), 32'h200 + 4 * k);
        chk("slow_addr_stable", unstable, 0);

        // Reset during refill word 4.
        rd_req = 1'b1;
        addr   = 32'h0000_0300;
        found  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (mem_req && mem_addr == 32'h310) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_mid_reached_word4", {31'd0, found}, 32'h1);
        rst = 1'b0;
        #1;
        chk("rst_mid_mem_req", {31'd0, mem_req}, 32'h0);
        chk("rst_mid_mem_addr", mem_addr, 32'h0);
        rd_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_rd_data", rd_data, 32'h0);
        access(1'b1, 4'b0000, 32'h0000_0300, 32'h0, mc, rd);
        chk("rst_mid_remiss_cycles", mc, 10);
        chk("rst_mid_rd_data2", rd, 32'hD000_0000);

        // Further hits and clean misses for the counters.
        access(1'b1, 4'b0000, 32'h0000_0304, 32'h0, mc, rd);
        chk("hit304_cycles", mc, 0);
        chk("hit304_data", rd, 32'hD000_0001);
        access(1'b1, 4'b0000, 32'h0000_0308, 32'h0, mc, rd);
        chk("hit308_data", rd, 32'hD000_0002);
        access(1'b1, 4'b0000, 32'h0000_0400, 32'h0, mc, rd);
        chk("miss400_cycles", mc, 10);
        chk("miss400_data", rd, 32'hE000_0000);
        access(1'b1, 4'b0000, 32'h0000_0500, 32'h0, mc, rd);
        chk("miss500_cycles", mc, 10);
        chk("miss500_data", rd, 32'hF000_0000);

`ifdef DCACHE_PERF_CNT_EN
        exp_hits   = 32'd5;
        exp_misses = 32'd3;
`else
        exp_hits   = 32'd0;
        exp_misses = 32'd0;
`endif
        chk("perf_hit_cnt", hit_cnt, exp_hits);
        chk("perf_miss_cnt", miss_cnt, exp_misses);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
